// File: rtl/seq_restoring_divider_if.sv
// ============================================================================
// Module  : seq_restoring_divider_if
// Brief   : start/busy/done handshake and operand/result bus for the divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_restoring_divider_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
// ============================================================================
// Module  : seq_restoring_divider
// Brief   : Iterative restoring divider, one quotient bit per clock.
//           Define SEQ_DIV_SIGNED_EN for two's-complement operands.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    seq_restoring_divider_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_abs_dividend;
    logic [WIDTH-1:0] w_abs_divisor;

`ifdef SEQ_DIV_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;

    assign w_abs_dividend = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    assign w_abs_divisor  = bus.divisor[WIDTH-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;
`else
    assign w_abs_dividend = bus.dividend;
    assign w_abs_divisor  = bus.divisor;
`endif

    assign w_shifted = {rem_q, dvd_q[WIDTH-1]};
    assign w_trial   = w_shifted - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    dvd_d = w_abs_dividend;
                    dvs_d = w_abs_divisor;
                    rem_d = '0;
                    cnt_d = CW'(WIDTH - 1);
`ifdef SEQ_DIV_SIGNED_EN
                    qneg_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    rneg_d = bus.dividend[WIDTH-1];
`endif
                    if (bus.divisor != '0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                        quo_d   = '1;
                        remo_d  = bus.dividend;
                        dbz_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // Sign bit of the WIDTH+1-bit trial set means shifted < divisor: restore.
                dvd_d = {dvd_q[WIDTH-2:0], ~w_trial[WIDTH]};
                rem_d = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    dbz_d   = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
                    quo_d   = qneg_q ? (~dvd_d + 1'b1) : dvd_d;
                    remo_d  = rneg_q ? (~rem_d + 1'b1) : rem_d;
`else
                    quo_d   = dvd_d;
                    remo_d  = rem_d;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign bus.busy        = (state_q == S_RUN);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = remo_q;
    assign bus.div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// Module  : tb_seq_restoring_divider
// Brief   : Self-checking bench for seq_restoring_divider against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
`ifdef SEQ_DIV_SIGNED_EN
        int sa, sb, tq, tr;
        sa = $signed(a);
        sb = $signed(b);
        if (sb == 0) begin
            q = '1; r = a; z = 1'b1;
        end else if (sa == -(1 << (W - 1)) && sb == -1) begin
            q = a; r = '0; z = 1'b0;
        end else begin
            tq = sa / sb;
            tr = sa % sb;
            q = tq[W-1:0]; r = tr[W-1:0]; z = 1'b0;
        end
`else
        if (b == '0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
`endif
    endfunction

    // Launch one operation from the current time; returns results, edges until done, busy cycles.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                          output int lat, output int busycnt);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        busycnt = 0;
        for (int k = 0; k <= 3 * W; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.busy) busycnt++;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        q = bus.quotient;
        r = bus.remainder;
        z = bus.div_by_zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] q, r; logic z; int lat, bc;
        run_op(8'd100, 8'd7, q, r, z, lat, bc);
        checks++;
        if ({q, r, z} !== {8'd14, 8'd2, 1'b0}) begin
            errors++;
            $display("FAIL basic_100_7: got q=%0d r=%0d dbz=%b, want q=14 r=2 dbz=0", q, r, z);
        end
        checks++;
        if (lat !== W) begin
            errors++;
            $display("FAIL basic_latency: got %0d, want %0d", lat, W);
        end
        checks++;
        if (bc !== W) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, want %0d", bc, W);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.quotient !== 8'd14) begin
            errors++;
            $display("FAIL done_pulse_hold: got done=%b q=%0d, want done=0 q=14", bus.done, bus.quotient);
        end
    endtask

    task automatic test_extremes();
        logic [W-1:0] q, r; logic z; int lat, bc;
        run_op(8'd255, 8'd1, q, r, z, lat, bc);
        checks++;
        if ({q, r, lat} !== {8'd255, 8'd0, W}) begin
            errors++;
            $display("FAIL extreme_255_1: got q=%0d r=%0d lat=%0d, want q=255 r=0 lat=%0d", q, r, lat, W);
        end
        run_op(8'd3, 8'd200, q, r, z, lat, bc);
        checks++;
        if ({q, r, lat} !== {8'd0, 8'd3, W}) begin
            errors++;
            $display("FAIL extreme_3_200: got q=%0d r=%0d lat=%0d, want q=0 r=3 lat=%0d", q, r, lat, W);
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] q, r; logic z; int lat, bc;
        run_op(8'd5, 8'd0, q, r, z, lat, bc);
        checks++;
        if ({q, r, z} !== {8'hFF, 8'd5, 1'b1}) begin
            errors++;
            $display("FAIL div_zero_result: got q=%h r=%0d dbz=%b, want q=ff r=5 dbz=1", q, r, z);
        end
        checks++;
        if (lat !== 0 || bc !== 0) begin
            errors++;
            $display("FAIL div_zero_timing: got lat=%0d busy=%0d, want lat=0 busy=0", lat, bc);
        end
    endtask

    task automatic test_start_during_busy();
        logic [W-1:0] q, r; logic z; int lat, bc;
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        for (int k = 3; k <= 3 * W; k++) begin
            if (bus.done) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if ({bus.quotient, bus.remainder, lat} !== {8'd14, 8'd2, W}) begin
            errors++;
            $display("FAIL ignore_start_busy: got q=%0d r=%0d lat=%0d, want q=14 r=2 lat=%0d",
                     bus.quotient, bus.remainder, lat, W);
        end
        run_op(8'd9, 8'd3, q, r, z, lat, bc);
        checks++;
        if ({q, r, z, lat} !== {8'd3, 8'd0, 1'b0, W}) begin
            errors++;
            $display("FAIL start_in_done: got q=%0d r=%0d dbz=%b lat=%0d, want q=3 r=0 dbz=0 lat=%0d",
                     q, r, z, lat, W);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] q, r, eq, er; logic z, ez; int lat, bc;
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(8'd200, 8'd9, q, r, z, lat, bc);
        ref_div(8'd200, 8'd9, eq, er, ez);
        checks++;
        if ({q, r, z, lat} !== {eq, er, ez, W}) begin
            errors++;
            $display("FAIL after_reset_200_9: got q=%0d r=%0d lat=%0d, want q=%0d r=%0d lat=%0d",
                     q, r, lat, eq, er, W);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er; logic z, ez; int lat, bc;
        for (int i = 0; i < 24; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            ref_div(a, b, eq, er, ez);
            run_op(a, b, q, r, z, lat, bc);
            checks++;
            if ({q, r, z} !== {eq, er, ez} || lat !== (ez ? 0 : W) || bc !== (ez ? 0 : W)) begin
                errors++;
                $display("FAIL random %h/%h: got q=%h r=%h dbz=%b lat=%0d busy=%0d, want q=%h r=%h dbz=%b",
                         a, b, q, r, z, lat, bc, eq, er, ez);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b, eq, er; logic ez; int lat;
        a = W'($urandom); b = W'($urandom_range(1, 255));
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        for (int n = 0; n < 5; n++) begin
            ref_div(a, b, eq, er, ez);
            @(posedge clk);
            #1;
            // Scramble operands while running; they must not be recaptured.
            bus.dividend = W'($urandom); bus.divisor = W'($urandom);
            lat = -1;
            for (int k = 0; k <= 3 * W; k++) begin
                if (k > 0) begin
                    @(posedge clk);
                    #1;
                end
                if (bus.done) begin
                    lat = k;
                    break;
                end
            end
            checks++;
            if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {eq, er, ez} || lat !== (ez ? 0 : W)) begin
                errors++;
                $display("FAIL back_to_back %0d (%h/%h): got q=%h r=%h dbz=%b lat=%0d, want q=%h r=%h dbz=%b",
                         n, a, b, bus.quotient, bus.remainder, bus.div_by_zero, lat, eq, er, ez);
            end
            a = W'($urandom);
            b = (n == 2) ? '0 : W'($urandom_range(1, 255));
            bus.dividend = a; bus.divisor = b;
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
    endtask

`ifdef SEQ_DIV_SIGNED_EN
    task automatic test_signed();
        logic [W-1:0] q, r; logic z; int lat, bc;
        run_op(8'hF9, 8'h02, q, r, z, lat, bc);
        checks++;
        if ({q, r} !== {8'hFD, 8'hFF}) begin
            errors++;
            $display("FAIL signed_m7_2: got q=%h r=%h, want q=fd r=ff", q, r);
        end
        run_op(8'h07, 8'hFE, q, r, z, lat, bc);
        checks++;
        if ({q, r} !== {8'hFD, 8'h01}) begin
            errors++;
            $display("FAIL signed_7_m2: got q=%h r=%h, want q=fd r=01", q, r);
        end
        run_op(8'h80, 8'hFF, q, r, z, lat, bc);
        checks++;
        if ({q, r, z, lat} !== {8'h80, 8'h00, 1'b0, W}) begin
            errors++;
            $display("FAIL signed_overflow: got q=%h r=%h dbz=%b lat=%0d, want q=80 r=00 dbz=0 lat=%0d",
                     q, r, z, lat, W);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_start_during_busy();
        test_reset_mid_op();
        test_random();
        test_back_to_back();
`ifdef SEQ_DIV_SIGNED_EN
        test_signed();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
